// File: rtl/asrv32_memoryaccess.sv
`default_nettype none
// ============================================================================
//  Module   : asrv32_memoryaccess
//  Purpose  : Memory-access stage of the asrv32 multi-cycle core. LOAD/STORE
//             run one pipelined Wishbone-B4 transfer at the ALU address and
//             return formatted (aligned, sign/zero-extended) load data to the
//             writeback stage; every other opcode completes in one cycle.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_memoryaccess_en, i_opcode, i_funct3, i_rs2_data, i_addr
//             o_load_data, o_done, o_addr_fault, o_bus_err
//             Wishbone master: o_wb_cyc/stb/we/addr/data/sel,
//                              i_wb_data/ack/stall
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module asrv32_memoryaccess #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_memoryaccess_en,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]               i_funct3,
    input  logic [31:0]              i_rs2_data,
    input  logic [31:0]              i_addr,
    output logic [31:0]              o_load_data,
    output logic                     o_done,
    output logic                     o_addr_fault,
    output logic                     o_bus_err,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [31:0]              o_wb_addr,
    output logic [31:0]              o_wb_data,
    output logic [3:0]               o_wb_sel,
    input  logic [31:0]              i_wb_data,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic [31:0]          load_data_q, load_data_d;
    logic                 done_q, done_d;
    logic                 addr_fault_q, addr_fault_d;
    logic                 bus_err_q, bus_err_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [31:0]          wb_addr_q, wb_addr_d;
    logic [31:0]          wb_data_q, wb_data_d;
    logic [3:0]           sel_q, sel_d;

    // Only the LOAD/STORE bits of the one-hot opcode matter here.
    logic w_unused_opcode;
    assign w_unused_opcode = ^i_opcode;

    logic w_is_load, w_is_store, w_is_mem;
    assign w_is_load  = i_opcode[`LOAD];
    assign w_is_store = i_opcode[`STORE];
    assign w_is_mem   = w_is_load | w_is_store;

    // Request decode from the live inputs (only consumed in IDLE).
    logic        w_funct3_ok, w_misaligned, w_fault;
    logic [3:0]  w_sel;
    logic [31:0] w_store_data;

    always_comb begin
        w_funct3_ok = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: w_funct3_ok = 1'b1;
            3'b100, 3'b101:         w_funct3_ok = w_is_load;
            default:                w_funct3_ok = 1'b0;
        endcase

        w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        w_fault      = !w_funct3_ok || w_misaligned;

        case (i_funct3[1:0])
            2'b00: begin
                w_sel        = 4'b0001 << i_addr[1:0];
                w_store_data = {4{i_rs2_data[7:0]}};
            end
            2'b01: begin
                w_sel        = 4'b0011 << {i_addr[1], 1'b0};
                w_store_data = {2{i_rs2_data[15:0]}};
            end
            default: begin
                w_sel        = 4'b1111;
                w_store_data = i_rs2_data;
            end
        endcase
    end

    // Load formatting uses the width/offset latched when the request issued.
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load_fmt;

    always_comb begin
        w_lane_b = 8'(i_wb_data >> {off_q, 3'b000});
        w_lane_h = 16'(i_wb_data >> {off_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  w_load_fmt = {{24{w_lane_b[7]}}, w_lane_b};
            3'b100:  w_load_fmt = {24'd0, w_lane_b};
            3'b001:  w_load_fmt = {{16{w_lane_h[15]}}, w_lane_h};
            3'b101:  w_load_fmt = {16'd0, w_lane_h};
            default: w_load_fmt = i_wb_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        load_data_d  = load_data_q;
        done_d       = 1'b0;
        addr_fault_d = 1'b0;
        bus_err_d    = 1'b0;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        sel_d        = sel_q;

        case (state_q)
            S_IDLE: begin
                if (i_memoryaccess_en) begin
                    if (!w_is_mem) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (w_fault) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        addr_fault_d = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        cyc_d     = 1'b1;
                        stb_d     = 1'b1;
                        we_d      = w_is_store;
                        wb_addr_d = {i_addr[31:2], 2'b00};
                        wb_data_d = w_store_data;
                        sel_d     = w_sel;
                        funct3_d  = i_funct3;
                        off_d     = i_addr[1:0];
                    end
                end
            end

            S_REQ: begin
                // Request signals stay frozen until the slave stops stalling.
                if (!i_wb_stall) begin
                    stb_d = 1'b0;
                    if (i_wb_ack) begin
                        state_d = S_DONE;
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        if (!we_q) begin
                            load_data_d = w_load_fmt;
                        end
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end

            S_WAIT: begin
                // Ack wins over a timeout landing in the same cycle.
                if (i_wb_ack) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        load_data_d = w_load_fmt;
                    end
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d   = S_DONE;
                    cyc_d     = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            load_data_q  <= '0;
            done_q       <= 1'b0;
            addr_fault_q <= 1'b0;
            bus_err_q    <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            load_data_q  <= load_data_d;
            done_q       <= done_d;
            addr_fault_q <= addr_fault_d;
            bus_err_q    <= bus_err_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            sel_q        <= sel_d;
        end
    end

    assign o_load_data  = load_data_q;
    assign o_done       = done_q;
    assign o_addr_fault = addr_fault_q;
    assign o_bus_err    = bus_err_q;
    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = we_q;
    assign o_wb_addr    = wb_addr_q;
    assign o_wb_data    = wb_data_q;
    assign o_wb_sel     = sel_q;

endmodule

`default_nettype wire
